// File: rtl/prog_launcher.sv
// Resets the processor once, then launches NPROG programs back to back via Start/Ack and reports each program's cycle count.
// All outputs registered (one cycle after the state decision); Go is ignored while a batch runs; aborts the batch on timeout.
module prog_launcher #(
    parameter int NPROG   = 3,
    parameter int CW      = 16,
    parameter int TIMEOUT = 16'hFFF,
    parameter int RST_CYC = 2,
    localparam int IW     = (NPROG > 1) ? $clog2(NPROG) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Go,
    input  logic          ProcAck,
    output logic          ProcReset,
    output logic          ProcStart,
    output logic [IW-1:0] ProgIdx,
    output logic [CW-1:0] CycleCount,
    output logic          CountValid,
    output logic          Busy,
    output logic          Done,
    output logic          TimedOut
);

    localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RW-1:0] RC_LAST   = RW'(RST_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NPROG - 1);
    localparam logic [CW-1:0] TO        = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_START, S_ARM, S_RUN, S_REPORT, S_DONE
    } state_t;

    state_t        state, state_nx;
    logic [RW-1:0] rc, rc_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    logic          go_acc, running, timeout_hit;

    logic          proc_reset_nx, proc_start_nx, count_valid_nx;
    logic          busy_nx, done_nx, timed_out_nx;
    logic [IW-1:0] prog_idx_nx;
    logic [CW-1:0] cycle_count_nx;

    // cnt holds the ARM/RUN cycles already elapsed; cnt_inc includes the current one
    assign cnt_inc     = (cnt == TO) ? cnt : cnt + 1'b1;
    assign running     = (state == S_ARM) || (state == S_RUN);
    assign go_acc      = ((state == S_IDLE) || (state == S_DONE)) && Go;
    assign timeout_hit = running && (cnt_inc == TO);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= S_IDLE;
            rc         <= '0;
            cnt        <= '0;
            ProcReset  <= 1'b1;
            ProcStart  <= 1'b0;
            ProgIdx    <= '0;
            CycleCount <= '0;
            CountValid <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            TimedOut   <= 1'b0;
        end else begin
            state      <= state_nx;
            rc         <= rc_nx;
            cnt        <= cnt_nx;
            ProcReset  <= proc_reset_nx;
            ProcStart  <= proc_start_nx;
            ProgIdx    <= prog_idx_nx;
            CycleCount <= cycle_count_nx;
            CountValid <= count_valid_nx;
            Busy       <= busy_nx;
            Done       <= done_nx;
            TimedOut   <= timed_out_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (Go) state_nx = S_RST;
            S_RST:          if (rc == RC_LAST) state_nx = S_START;
            S_START:        state_nx = S_ARM;
            // A stale Ack from the previous halt must drop before completion is armed
            S_ARM: begin
                if (timeout_hit)   state_nx = S_DONE;
                else if (!ProcAck) state_nx = S_RUN;
            end
            S_RUN: begin
                if (ProcAck)          state_nx = S_REPORT;
                else if (timeout_hit) state_nx = S_DONE;
            end
            S_REPORT:       state_nx = (ProgIdx == IDX_LAST) ? S_DONE : S_START;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        rc_nx          = '0;
        cnt_nx         = cnt;
        proc_reset_nx  = (state_nx == S_IDLE) || (state_nx == S_RST);
        proc_start_nx  = (state_nx == S_START);
        count_valid_nx = (state_nx == S_REPORT);
        busy_nx        = (state_nx != S_IDLE) && (state_nx != S_DONE);
        done_nx        = (state_nx == S_DONE);
        prog_idx_nx    = ProgIdx;
        cycle_count_nx = CycleCount;
        timed_out_nx   = TimedOut;

        if (state == S_RST)
            rc_nx = rc + 1'b1;
        if (state_nx == S_START)
            cnt_nx = '0;
        else if (running)
            cnt_nx = cnt_inc;

        if (go_acc) begin
            prog_idx_nx  = '0;
            timed_out_nx = 1'b0;
        end
        if (state == S_RUN && ProcAck)
            cycle_count_nx = cnt_inc;
        if (state == S_REPORT && state_nx == S_START)
            prog_idx_nx = ProgIdx + 1'b1;
        if (running && state_nx == S_DONE)
            timed_out_nx = 1'b1;
    end

endmodule
